// File: rtl/wptr_full_ctrl_if.sv
// rtl/wptr_full_ctrl_if.sv - producer-side handshake and status bundle for the write-pointer controller
interface wptr_full_ctrl_if #(
    parameter int PTR_WIDTH = 3
);
    logic                 w_en;
    logic                 clr_ovf;
    logic                 w_accept;
    logic                 full;
    logic                 almost_full;
    logic                 overflow;
    logic [PTR_WIDTH:0]   wr_level;

    modport master (
        output w_en, clr_ovf,
        input  w_accept, full, almost_full, overflow, wr_level
    );

    modport slave (
        input  w_en, clr_ovf,
        output w_accept, full, almost_full, overflow, wr_level
    );
endinterface

// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - async FIFO write pointer, full/almost-full/level/overflow generation
module wptr_full_ctrl #(
    parameter int PTR_WIDTH    = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic               wclk,
    input  logic               wrst,
    input  logic [PTR_WIDTH:0] g_rptr,
    output logic [PTR_WIDTH:0] b_wptr,
    output logic [PTR_WIDTH:0] g_wptr,
    wptr_full_ctrl_if.slave    wif
);
    localparam int MSB = PTR_WIDTH;
    localparam int AFULL_INT = AFULL_THRESH;
    localparam logic [PTR_WIDTH:0] AFULL_LVL = AFULL_INT[PTR_WIDTH:0];

    logic [PTR_WIDTH:0] b_wptr_q, b_wptr_d;
    logic [PTR_WIDTH:0] g_wptr_q, g_wptr_d;
    logic [PTR_WIDTH:0] g_rptr_s1_q, g_rptr_s1_d;
    logic [PTR_WIDTH:0] g_rptr_sync_q, g_rptr_sync_d;
    logic [PTR_WIDTH:0] wr_level_q, wr_level_d;
    logic               full_q, full_d;
    logic               almost_full_q, almost_full_d;
    logic               overflow_q, overflow_d;

    logic [PTR_WIDTH:0] b_rptr_sync;
    logic [PTR_WIDTH:0] level_next;
    logic               w_accept;

    always_comb begin
        b_rptr_sync = '0;
        for (int i = 0; i <= MSB; i++) begin
            b_rptr_sync[i] = ^(g_rptr_sync_q >> i);
        end
    end

    // Reset gates the accept so no memory write can slip through during wrst.
    assign w_accept = wif.w_en & ~full_q & ~wrst;

    always_comb begin
        g_rptr_s1_d   = g_rptr;
        g_rptr_sync_d = g_rptr_s1_q;
        b_wptr_d      = b_wptr_q + {{PTR_WIDTH{1'b0}}, w_accept};
        g_wptr_d      = (b_wptr_d >> 1) ^ b_wptr_d;
        level_next    = b_wptr_d - b_rptr_sync;
        // Full when write Gray equals read Gray with the two MSBs inverted.
        full_d        = (g_wptr_d == {~g_rptr_sync_q[MSB:MSB-1], g_rptr_sync_q[MSB-2:0]});
        wr_level_d    = level_next;
        almost_full_d = (level_next >= AFULL_LVL);
        overflow_d    = overflow_q;
        if (wif.clr_ovf) begin
            overflow_d = 1'b0;
        end
        if (wif.w_en && full_q) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            b_wptr_q      <= '0;
            g_wptr_q      <= '0;
            g_rptr_s1_q   <= '0;
            g_rptr_sync_q <= '0;
            wr_level_q    <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            b_wptr_q      <= b_wptr_d;
            g_wptr_q      <= g_wptr_d;
            g_rptr_s1_q   <= g_rptr_s1_d;
            g_rptr_sync_q <= g_rptr_sync_d;
            wr_level_q    <= wr_level_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    assign b_wptr          = b_wptr_q;
    assign g_wptr          = g_wptr_q;
    assign wif.w_accept    = w_accept;
    assign wif.full        = full_q;
    assign wif.almost_full = almost_full_q;
    assign wif.overflow    = overflow_q;
    assign wif.wr_level    = wr_level_q;
endmodule

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 SHALL provide parameter PTR_WIDTH, default 3; FIFO depth = 2**PTR_WIDTH; all pointers are PTR_WIDTH+1 bits.
REQ-002 SHALL provide parameter AFULL_THRESH, default 6; fill level at or above which almost_full asserts; legal range 1..2**PTR_WIDTH.
REQ-003 SHALL provide port wclk, input, 1, write-domain clock; it is the only clock.
REQ-004 SHALL provide port wrst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL provide port w_en, input, 1, write request from the producer.
REQ-006 SHALL provide port g_rptr, input, PTR_WIDTH+1, Gray read pointer from the read domain; asynchronous to wclk.
REQ-007 SHALL provide port clr_ovf, input, 1, clears the sticky overflow flag.
REQ-008 SHALL provide port b_wptr, output, PTR_WIDTH+1, binary write pointer; low PTR_WIDTH bits address the memory.
REQ-009 SHALL provide port g_wptr, output, PTR_WIDTH+1, Gray write pointer for the read-domain synchronizer.
REQ-010 SHALL provide port w_accept, output, 1, combinational w_en & !full; qualifies the memory write in the current cycle.
REQ-011 SHALL provide port full, output, 1, registered full flag.
REQ-012 SHALL provide port almost_full, output, 1, registered almost-full flag.
REQ-013 SHALL provide port wr_level, output, PTR_WIDTH+1, registered fill level as seen from the write domain (0..2**PTR_WIDTH).
REQ-014 SHALL provide port overflow, output, 1, sticky flag set by a write attempted while full.

Function
REQ-015 SHALL pass g_rptr through a two-flop synchronizer clocked by wclk (g_rptr_s1 -> g_rptr_sync); no logic between the two stages.
REQ-016 SHALL convert g_rptr_sync to binary b_rptr_sync by XOR-prefix from the MSB down, combinationally.
REQ-017 SHALL compute b_wptr_next = b_wptr + w_accept, modulo 2**(PTR_WIDTH+1); the wrap from all-ones to zero is legal.
REQ-018 SHALL compute g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next, and register both b_wptr and g_wptr from the _next values each cycle.
REQ-019 SHALL register full <= (g_wptr_next == {~g_rptr_sync[MSB:MSB-1], g_rptr_sync[MSB-2:0]}).
REQ-020 SHALL register wr_level <= b_wptr_next - b_rptr_sync, truncated to PTR_WIDTH+1 bits; wr_level == 2**PTR_WIDTH exactly when full is set.
REQ-021 SHALL register almost_full <= (b_wptr_next - b_rptr_sync) >= AFULL_THRESH.
REQ-022 SHALL block all writes while full: w_accept = 0, and the pointers hold.
REQ-023 SHALL set overflow on a cycle where w_en & full; clr_ovf clears it; set has priority when both occur in the same cycle.
REQ-024 SHALL make flag latency one wclk after the accepted write; release of full/almost_full after a read lags the g_rptr change by 2-3 wclk cycles (pessimistic, never optimistic).
REQ-025 SHALL never accept a write that would make the true occupancy exceed 2**PTR_WIDTH, for any phase relation between wclk and the read clock.

Reset
REQ-026 SHALL, on wclk edge with wrst=1, clear b_wptr, g_wptr, g_rptr_s1, g_rptr_sync, wr_level, full, almost_full, overflow to 0; reset overrides w_en and clr_ovf.
REQ-027 SHALL, with wrst=1, force w_accept = 0 combinationally so no memory write occurs during reset.
REQ-028 SHALL, on wrst asserted mid-operation, discard all state; the read side is reset in the same system reset, otherwise behaviour is undefined.

Verification
REQ-029 SHALL cover: reset, g_rptr=0, w_en=1 for 8 cycles -> b_wptr 0..8, g_wptr final 4'b1100, wr_level 8, full=1 one cycle after the 8th accept, almost_full=1 after the 6th.
REQ-030 SHALL cover: full=1, w_en=1 for 3 cycles -> b_wptr holds at 8, w_accept=0, overflow=1 and stays set; clr_ovf pulse with w_en=0 -> overflow=0 next cycle.
REQ-031 SHALL cover: full, then g_rptr stepped to Gray(1)=4'b0001 -> full=0 and wr_level=7 by the 3rd wclk edge, not before the 2nd.
REQ-032 SHALL cover: wrap-around; 20 writes interleaved with matching g_rptr advances -> b_wptr passes 15 -> 0, wr_level never exceeds 8, no false full.
REQ-033 SHALL cover: wrst=1 asserted with wr_level=5 and w_en=1 -> next cycle all outputs 0, w_accept=0 during reset.
REQ-034 SHALL cover: w_en & full together with clr_ovf=1 -> overflow remains 1.
